cache_req_driver: RTL and testbench

//  Initiator side of the cache lookup handshake. Accepts byte addresses from a trace source and splits each into tag/index/block_offset.

---
 rtl/cache_sim_pkg.sv | 31 +++
 rtl/prefetch_buffer.sv | 65 ++++++
 rtl/cache_req_driver.sv | 161 ++++++++++++++++
 tb/tb_cache_req_driver.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/cache_sim_pkg.sv
// Shared types and geometry helpers for the cache request driver.
// Field widths are derived from the cache geometry parameters.
package cache_sim_pkg;

    localparam int CNT_W = 20;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_UPD,
        WAIT_CLR
    } state_t;

    function automatic int off_w(input int blk);
        return $clog2(blk);
    endfunction

    function automatic int idx_w(input int cache, input int blk, input int way);
        return $clog2(cache / (blk * way));
    endfunction

    function automatic int tag_w(input int cache, input int blk, input int way);
        return 32 - idx_w(cache, blk, way) - off_w(blk);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/prefetch_buffer.sv
// Next-line prefetch buffer: small FIFO-replaced set of block addresses.
// Lookup is combinational; invalidate and insert update on the clock edge.
module prefetch_buffer #(
    parameter int DEPTH = 4,
    parameter int BA_W  = 28
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [BA_W-1:0] lookup_ba,
    output logic            lookup_hit,
    input  logic            inv_en,
    input  logic [BA_W-1:0] inv_ba,
    input  logic            ins_en,
    input  logic [BA_W-1:0] ins_ba
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0] vld_q, vld_d;
    logic [BA_W-1:0]  ba_q [DEPTH];
    logic [BA_W-1:0]  ba_d [DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             ins_dup;

    // Match lookup and pending insert address against valid entries
    always_comb begin
        lookup_hit = 1'b0;
        ins_dup    = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && ba_q[i] == lookup_ba) lookup_hit = 1'b1;
            if (vld_q[i] && ba_q[i] == ins_ba)    ins_dup    = 1'b1;
        end
    end

    // Invalidate matching entry; insert at ptr unless already present
    always_comb begin
        vld_d = vld_q;
        ba_d  = ba_q;
        ptr_d = ptr_q;
        if (inv_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (vld_q[i] && ba_q[i] == inv_ba) vld_d[i] = 1'b0;
            end
        end
        if (ins_en && !ins_dup) begin
            vld_d[ptr_q] = 1'b1;
            ba_d[ptr_q]  = ins_ba;
            ptr_d        = ptr_q + 1'b1;
        end
    end

    // Entry storage and write pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) ba_q[i] <= '0;
        end else begin
            vld_q <= vld_d;
            ptr_q <= ptr_d;
            ba_q  <= ba_d;
        end
    end

endmodule

// File: rtl/cache_req_driver.sv
// Initiator side of the cache lookup handshake with next-line prefetch.
// Splits trace addresses, issues one lookup at a time, tracks statistics.
module cache_req_driver
    import cache_sim_pkg::*;
#(
    parameter int WAY             = 4,
    parameter int BLOCK_SIZE_BYTE = 16,
    parameter int CACHE_SIZE_BYTE = 32768,
    parameter int PB_DEPTH        = 4,
    parameter int TIMEOUT         = 1023,
    localparam int OFF_W = off_w(BLOCK_SIZE_BYTE),
    localparam int IDX_W = idx_w(CACHE_SIZE_BYTE, BLOCK_SIZE_BYTE, WAY),
    localparam int TAG_W = tag_w(CACHE_SIZE_BYTE, BLOCK_SIZE_BYTE, WAY)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             addr_valid,
    input  logic [31:0]      addr,
    output logic             addr_ready,
    output logic [TAG_W-1:0] tag,
    output logic [IDX_W-1:0] index,
    output logic [OFF_W-1:0] block_offset,
    output logic             find_start,
    output logic             prefetch_hit,
    input  logic             updated,
    input  logic             found_in_cache,
    output logic [CNT_W-1:0] req_count,
    output logic [CNT_W-1:0] pf_hit_count,
    output logic             busy,
    output logic             timeout_err
);

    localparam int BA_W = 32 - OFF_W;
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT);

    state_t           state_q, state_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [OFF_W-1:0] off_q, off_d;
    logic [BA_W-1:0]  ba_q, ba_d;
    logic             pf_q, pf_d;
    logic             found_q, found_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [CNT_W-1:0] req_q, req_d;
    logic [CNT_W-1:0] pfc_q, pfc_d;
    logic             terr_q, terr_d;

    logic             pb_hit;
    logic             pb_inv;
    logic             pb_ins;

    prefetch_buffer #(
        .DEPTH (PB_DEPTH),
        .BA_W  (BA_W)
    ) u_pb (
        .clk        (clk),
        .rst        (rst),
        .lookup_ba  (addr[31:OFF_W]),
        .lookup_hit (pb_hit),
        .inv_en     (pb_inv),
        .inv_ba     (ba_q),
        .ins_en     (pb_ins),
        .ins_ba     (ba_q + 1'b1)
    );

    // Handshake FSM: next state, field latching, counters, PB control
    always_comb begin
        state_d  = state_q;
        tag_d    = tag_q;
        idx_d    = idx_q;
        off_d    = off_q;
        ba_d     = ba_q;
        pf_d     = pf_q;
        found_d  = found_q;
        to_cnt_d = to_cnt_q;
        req_d    = req_q;
        pfc_d    = pfc_q;
        terr_d   = terr_q;
        pb_inv   = 1'b0;
        pb_ins   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (addr_valid) begin
                    tag_d   = addr[31:IDX_W+OFF_W];
                    idx_d   = addr[IDX_W+OFF_W-1:OFF_W];
                    off_d   = addr[OFF_W-1:0];
                    ba_d    = addr[31:OFF_W];
                    pf_d    = pb_hit;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                to_cnt_d = '0;
                state_d  = WAIT_UPD;
            end
            WAIT_UPD: begin
                if (updated) begin
                    found_d = found_in_cache;
                    pb_inv  = pf_q;
                    req_d   = sat_inc(req_q);
                    if (pf_q) pfc_d = sat_inc(pfc_q);
                    state_d = WAIT_CLR;
                end else if (to_cnt_q == TO_LAST) begin
                    terr_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            WAIT_CLR: begin
                if (!updated) begin
                    pb_ins  = !found_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            tag_q    <= '0;
            idx_q    <= '0;
            off_q    <= '0;
            ba_q     <= '0;
            pf_q     <= 1'b0;
            found_q  <= 1'b0;
            to_cnt_q <= '0;
            req_q    <= '0;
            pfc_q    <= '0;
            terr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tag_q    <= tag_d;
            idx_q    <= idx_d;
            off_q    <= off_d;
            ba_q     <= ba_d;
            pf_q     <= pf_d;
            found_q  <= found_d;
            to_cnt_q <= to_cnt_d;
            req_q    <= req_d;
            pfc_q    <= pfc_d;
            terr_q   <= terr_d;
        end
    end

    assign addr_ready   = (state_q == IDLE);
    assign find_start   = (state_q == ISSUE);
    assign busy         = (state_q != IDLE);
    assign tag          = tag_q;
    assign index        = idx_q;
    assign block_offset = off_q;
    assign prefetch_hit = pf_q;
    assign req_count    = req_q;
    assign pf_hit_count = pfc_q;
    assign timeout_err  = terr_q;

endmodule

// File: tb/tb_cache_req_driver.sv
// Directed bench for cache_req_driver with a cache BFM and a scoreboard.
// Expected address fields and prefetch hits are queued at drive time.
module tb_cache_req_driver;

    logic        clk;
    logic        rst;
    logic        addr_valid;
    logic [31:0] addr;
    logic        addr_ready;
    logic [18:0] tag;
    logic [8:0]  index;
    logic [3:0]  block_offset;
    logic        find_start;
    logic        prefetch_hit;
    logic        updated;
    logic        found_in_cache;
    logic [19:0] req_count;
    logic [19:0] pf_hit_count;
    logic        busy;
    logic        timeout_err;

    typedef struct packed {
        logic [18:0] tag;
        logic [8:0]  idx;
        logic [3:0]  off;
        logic        pf;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    logic bfm_en  = 1'b1;
    logic bfm_hit = 1'b0;
    int   bfm_lat = 2;

    cache_req_driver dut (
        .clk            (clk),
        .rst            (rst),
        .addr_valid     (addr_valid),
        .addr           (addr),
        .addr_ready     (addr_ready),
        .tag            (tag),
        .index          (index),
        .block_offset   (block_offset),
        .find_start     (find_start),
        .prefetch_hit   (prefetch_hit),
        .updated        (updated),
        .found_in_cache (found_in_cache),
        .req_count      (req_count),
        .pf_hit_count   (pf_hit_count),
        .busy           (busy),
        .timeout_err    (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cache BFM: updated pulses bfm_lat cycles after find_start, 1 cycle wide
    initial begin
        updated        = 1'b0;
        found_in_cache = 1'b0;
        forever begin
            @(negedge clk);
            if (find_start && bfm_en) begin
                repeat (bfm_lat) @(negedge clk);
                updated        = 1'b1;
                found_in_cache = bfm_hit;
                @(negedge clk);
                updated        = 1'b0;
                found_in_cache = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic accept(input logic [31:0] a, input logic exp_pf);
        exp_t e;
        int   n;
        e.tag = a[31:13];
        e.idx = a[12:4];
        e.off = a[3:0];
        e.pf  = exp_pf;
        sb.push_back(e);
        @(negedge clk);
        addr       = a;
        addr_valid = 1'b1;
        n = 0;
        while (!addr_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        addr_valid = 1'b0;
        addr       = $urandom;
        check("find_start_rise", find_start, 1);
        e = sb.pop_front();
        check("tag", tag, e.tag);
        check("index", index, e.idx);
        check("block_offset", block_offset, e.off);
        check("prefetch_hit", prefetch_hit, e.pf);
        @(posedge clk);
        #1;
        check("find_start_fall", find_start, 0);
    endtask

    task automatic req(input logic [31:0] a, input logic hit,
                       input logic exp_pf);
        int n;
        bfm_hit = hit;
        accept(a, exp_pf);
        n = 0;
        while (busy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("return_idle", busy, 0);
    endtask

    task automatic counts(input int r, input int p);
        check("req_count", req_count, r);
        check("pf_hit_count", pf_hit_count, p);
    endtask

    initial begin
        int n;
        rst        = 1'b1;
        addr_valid = 1'b0;
        addr       = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_addr_ready", addr_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_find_start", find_start, 0);
        check("rst_tag", tag, 0);
        check("rst_pf", prefetch_hit, 0);
        check("rst_terr", timeout_err, 0);
        counts(0, 0);
        @(negedge clk);
        rst = 1'b0;

        // address split, hit path leaves PB alone
        req(32'h0001_2345, 1'b1, 1'b0);
        req(32'h0001_2355, 1'b1, 1'b0);
        counts(2, 0);

        // next-line prefetch hit then invalidation
        req(32'h0000_0100, 1'b0, 1'b0);
        req(32'h0000_0110, 1'b1, 1'b1);
        counts(4, 1);
        req(32'h0000_0110, 1'b1, 1'b0);
        counts(5, 1);

        // five misses overflow PB, oldest entry overwritten
        req(32'h0000_0100, 1'b0, 1'b0);
        req(32'h0000_0200, 1'b0, 1'b0);
        req(32'h0000_0300, 1'b0, 1'b0);
        req(32'h0000_0400, 1'b0, 1'b0);
        req(32'h0000_0500, 1'b0, 1'b0);
        req(32'h0000_0110, 1'b1, 1'b0);
        req(32'h0000_0210, 1'b1, 1'b1);
        counts(12, 2);

        // block address wraparound
        req(32'hFFFF_FFF0, 1'b0, 1'b0);
        req(32'h0000_0004, 1'b1, 1'b1);
        counts(14, 3);

        // timeout with no cache response
        bfm_en = 1'b0;
        accept(32'h0000_0700, 1'b0);
        repeat (1000) @(posedge clk);
        #1;
        check("no_early_timeout", timeout_err, 0);
        check("still_busy", busy, 1);
        n = 0;
        while (busy && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("timeout_err", timeout_err, 1);
        check("timeout_idle", busy, 0);
        check("timeout_ready", addr_ready, 1);
        counts(14, 3);

        // async reset in WAIT_UPD
        accept(32'h0000_0300, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("pre_rst_busy", busy, 1);
        #1;
        rst = 1'b1;
        #1;
        check("arst_find_start", find_start, 0);
        check("arst_busy", busy, 0);
        check("arst_ready", addr_ready, 1);
        check("arst_terr", timeout_err, 0);
        counts(0, 0);
        @(negedge clk);
        rst    = 1'b0;
        bfm_en = 1'b1;

        // BA 0x51 was valid before reset; PB must now be empty
        req(32'h0000_0510, 1'b1, 1'b0);
        counts(1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
